commit_trace_buffer: RTL and testbench
======================================

# commit_trace_buffer

Synthesizable commit-trace recorder for the processor cores: classifies each retired instruction (register write, load, store, store-with-update, halt, or no-op/branch) and stores it in a parametrised circular buffer, stamped with a 0-based instruction number. It is the on-chip successor of the simulation trace monitor. It supports multi-cycle and pipelined cores through an explicit commit strobe, and a bounded buffer with overflow accounting. It sits beside the writeback stage, and its drain port feeds the debug/trace export logic.

## Interface
- DATA_W, 16, width of PC, register data, memory address and memory data
- REG_W, 3, register-select width
- DEPTH, 16, buffer entries; power of two, ≥2
- CNT_W, 32, width of instruction/cycle/drop counters
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- commit_valid  in  1  one instruction retires this cycle
- commit_pc  in  DATA_W  PC of retiring instruction
- commit_reg_write, commit_mem_read, commit_mem_write, commit_halt  in  1 each  retire attributes
- commit_wreg  in  REG_W;  commit_wdata  in  DATA_W;  commit_mem_addr, commit_mem_data  in  DATA_W
- rd_valid  out  1  buffer non-empty
- rd_ready  in  1  consumer accepts head entry
- rd_kind  out  3  trace_pkg kind of head entry
- rd_inum  out  CNT_W;  rd_pc, rd_wdata, rd_addr, rd_mdata  out  DATA_W;  rd_wreg  out  REG_W
- inst_count, cycle_count, drop_count  out  CNT_W  running counters
- overflow  out  1  sticky: at least one entry was dropped
- halted  out  1  halt was recorded and buffer is fully drained

## Operation
- Kind priority on commit: HALT (commit_halt) > STU (reg_write & mem_write) > ST (mem_write) > LD (reg_write & mem_read) > REG (reg_write) > NOP (all other cases, including mem_read without reg_write).
- Unused fields are stored as zero: NOP/HALT keep only the PC; REG clears addr/mdata; LD clears mdata; ST clears wreg/wdata.
- rd_inum is inst_count sampled before the increment, so the first commit after reset has inum 0.
- Each accepted commit increments inst_count. When the buffer is full and no pop occurs that cycle, the entry is dropped: drop_count increments and overflow is set. Dropped commits still consume an inum.
- Full with a simultaneous pop: the push succeeds and nothing is dropped.
- Empty with a simultaneous push: rd_valid rises the next cycle. There is no bypass.
- FSM RUN → DRAIN when a HALT is pushed or dropped. DRAIN → DONE when the buffer is empty. DONE holds until rst.
- In DRAIN and DONE, commit_valid is ignored: no push, no count.
- A HALT is never dropped silently: a full buffer with a HALT commit still counts it as dropped.
- cycle_count increments every cycle in RUN, including the halt cycle, and freezes in DRAIN and DONE.
- halted = (state == DONE).
- Counters wrap modulo 2^CNT_W with no saturation.

## Timing
- Reset values: all counters 0, overflow 0, halted 0, rd_valid 0, rd_* outputs 0, state RUN, pointers 0.
- Assertion of rst at any time, including mid-drain, discards all buffered entries immediately.
- Commit inputs are sampled on the posedge of clk.
- Buffer is first-word-fall-through: rd_* show the head combinationally from storage and are valid whenever rd_valid=1.
- Pop occurs on a posedge with rd_valid & rd_ready.
- rd_ready while empty has no effect.
- Latency from commit to rd_valid is one cycle.
- Full throughput is one push and one pop per cycle.
- Pointers are log2(DEPTH) bits with an extra wrap bit for full/empty detection.

## Structure
- Package trace_pkg contains:
  - the 3-bit kind enum: NOP=0, REG=1, LD=2, ST=3, STU=4, HALT=5;
  - the packed trace_entry_t struct (kind, inum, pc, wreg, wdata, addr, mdata);
  - the FSM state enum.
- Sub-module trace_fifo is a generic FWFT circular buffer of trace_entry_t with DEPTH parameter, push/pop/full/empty.
- The top level holds the classifier, counters and FSM.

## Test plan
- Reset, then 3 commits (REG r2=0x1234 @0x0000, LD r3 addr 0x0040, ST addr 0x0042 data 0xBEEF) with rd_ready=1 → three entries with kinds 1, 2, 3 and inum 0, 1, 2; wdata/addr/mdata zeroed where unused.
- DEPTH=4, rd_ready=0, 6 commits → 4 entries holding inum 0–3, drop_count=2, overflow=1, inst_count=6.
- Full buffer with simultaneous commit and pop → no drop; the new entry appears last in the drain order.
- 2 commits then halt at PC 0x0010, with rd_ready held 0 for 5 cycles → cycle_count frozen and further commits ignored; after draining 3 entries, halted=1 and the last entry has kind 5 and pc 0x0010.
- Assert rst for one cycle mid-DRAIN → rd_valid=0, all counters 0, state RUN; the next commit gets inum 0.
- reg_write & mem_write (STU) and mem_read-only commits → kinds 4 and 0 respectively.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the commit-trace recorder: entry kinds, the stored entry, FSM states.
// Also holds the retire classifier so the field-clearing rules live in one place.
package trace_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int CNT_W  = 32;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    REG  = 3'd1,
    LD   = 3'd2,
    ST   = 3'd3,
    STU  = 3'd4,
    HALT = 3'd5
  } kind_e;

  typedef struct packed {
    kind_e              kind;
    logic [CNT_W-1:0]   inum;
    logic [DATA_W-1:0]  pc;
    logic [REG_W-1:0]   wreg;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  addr;
    logic [DATA_W-1:0]  mdata;
  } trace_entry_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Fields that have no meaning for the chosen kind are stored as zero.
  function automatic trace_entry_t classify(
    input logic              halt,
    input logic              reg_write,
    input logic              mem_read,
    input logic              mem_write,
    input logic [CNT_W-1:0]  inum,
    input logic [DATA_W-1:0] pc,
    input logic [REG_W-1:0]  wreg,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] addr,
    input logic [DATA_W-1:0] mdata
  );
    trace_entry_t e;
    e      = '0;
    e.inum = inum;
    e.pc   = pc;
    if (halt) begin
      e.kind = HALT;
    end else if (reg_write && mem_write) begin
      e.kind  = STU;
      e.wreg  = wreg;
      e.wdata = wdata;
      e.addr  = addr;
      e.mdata = mdata;
    end else if (mem_write) begin
      e.kind  = ST;
      e.addr  = addr;
      e.mdata = mdata;
    end else if (reg_write && mem_read) begin
      e.kind  = LD;
      e.wreg  = wreg;
      e.wdata = wdata;
      e.addr  = addr;
    end else if (reg_write) begin
      e.kind  = REG;
      e.wreg  = wreg;
      e.wdata = wdata;
    end else begin
      e.kind = NOP;
    end
    return e;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Retire-side commit bus plus the FWFT drain port of the trace buffer.
interface commit_trace_buffer_if;
  import trace_pkg::*;

  logic              commit_valid;
  logic [DATA_W-1:0] commit_pc;
  logic              commit_reg_write;
  logic              commit_mem_read;
  logic              commit_mem_write;
  logic              commit_halt;
  logic [REG_W-1:0]  commit_wreg;
  logic [DATA_W-1:0] commit_wdata;
  logic [DATA_W-1:0] commit_mem_addr;
  logic [DATA_W-1:0] commit_mem_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [2:0]        rd_kind;
  logic [CNT_W-1:0]  rd_inum;
  logic [DATA_W-1:0] rd_pc;
  logic [REG_W-1:0]  rd_wreg;
  logic [DATA_W-1:0] rd_wdata;
  logic [DATA_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_mdata;

  modport master (
    output commit_valid, commit_pc, commit_reg_write, commit_mem_read, commit_mem_write,
           commit_halt, commit_wreg, commit_wdata, commit_mem_addr, commit_mem_data, rd_ready,
    input  rd_valid, rd_kind, rd_inum, rd_pc, rd_wreg, rd_wdata, rd_addr, rd_mdata
  );

  modport slave (
    input  commit_valid, commit_pc, commit_reg_write, commit_mem_read, commit_mem_write,
           commit_halt, commit_wreg, commit_wdata, commit_mem_addr, commit_mem_data, rd_ready,
    output rd_valid, rd_kind, rd_inum, rd_pc, rd_wreg, rd_wdata, rd_addr, rd_mdata
  );

endinterface

// File: rtl/trace_fifo.sv
// FWFT circular buffer of trace entries; head visible combinationally, one-cycle push-to-visible.
// A push into a full buffer is accepted only when the head is popped on the same edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  trace_entry_t din_i,
  input  logic         pop_i,
  output trace_entry_t dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;
  trace_entry_t mem_q [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // When full, the write slot is the head being popped this edge, so overwriting it is safe.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace recorder: classifies retiring instructions, numbers them, buffers them for drain.
// Overflowing commits are counted and dropped; a recorded halt freezes capture until rst.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  commit_trace_buffer_if.slave  bus,
  output logic [CNT_W-1:0]      inst_count,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      drop_count,
  output logic                  overflow,
  output logic                  halted
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] inst_q, inst_d, cycle_q, cycle_d, drop_q, drop_d;
  logic             overflow_q, overflow_d;
  logic             run, accept, pop, push, drop, full, empty;
  trace_entry_t     new_entry, head;

  assign run    = (state_q == S_RUN);
  assign accept = run & bus.commit_valid;
  assign pop    = bus.rd_ready & ~empty;
  assign push   = accept & (~full | pop);
  assign drop   = accept & full & ~pop;

  assign new_entry = classify(bus.commit_halt, bus.commit_reg_write, bus.commit_mem_read,
                              bus.commit_mem_write, inst_q, bus.commit_pc, bus.commit_wreg,
                              bus.commit_wdata, bus.commit_mem_addr, bus.commit_mem_data);

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (new_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    cycle_d    = cycle_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    if (run)    cycle_d = cycle_q + ONE;
    if (accept) inst_d  = inst_q + ONE;
    if (drop) begin
      drop_d     = drop_q + ONE;
      overflow_d = 1'b1;
    end
    // A halt moves to DRAIN whether it was stored or dropped.
    case (state_q)
      S_RUN:   if (accept && bus.commit_halt) state_d = S_DRAIN;
      S_DRAIN: if (empty) state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      inst_q     <= '0;
      cycle_q    <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      cycle_q    <= cycle_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.rd_valid = ~empty;
  assign bus.rd_kind  = head.kind;
  assign bus.rd_inum  = head.inum;
  assign bus.rd_pc    = head.pc;
  assign bus.rd_wreg  = head.wreg;
  assign bus.rd_wdata = head.wdata;
  assign bus.rd_addr  = head.addr;
  assign bus.rd_mdata = head.mdata;

  assign inst_count  = inst_q;
  assign cycle_count = cycle_q;
  assign drop_count  = drop_q;
  assign overflow    = overflow_q;
  assign halted      = (state_q == S_DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with a queue scoreboard of buffered entries.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] inst_count, cycle_count, drop_count;
  logic             overflow, halted;

  commit_trace_buffer_if bus();

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .inst_count  (inst_count),
    .cycle_count (cycle_count),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_assert = 0;
  int               n_fail   = 0;
  trace_entry_t     q[$];
  trace_entry_t     cur_exp;
  state_e           m_state;
  logic [CNT_W-1:0] m_inst, m_cycle, m_drop;
  logic             m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic trace_entry_t mk(input kind_e k, input logic [15:0] pc,
                                      input logic [2:0] wreg, input logic [15:0] wdata,
                                      input logic [15:0] addr, input logic [15:0] mdata);
    trace_entry_t e;
    e      = '0;
    e.kind = k;
    e.pc   = pc;
    case (k)
      REG: begin e.wreg = wreg; e.wdata = wdata; end
      LD:  begin e.wreg = wreg; e.wdata = wdata; e.addr = addr; end
      ST:  begin e.addr = addr; e.mdata = mdata; end
      STU: begin e.wreg = wreg; e.wdata = wdata; e.addr = addr; e.mdata = mdata; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive(input logic rw, input logic mr, input logic mw, input logic h,
                       input logic [15:0] pc, input logic [2:0] wreg, input logic [15:0] wdata,
                       input logic [15:0] addr, input logic [15:0] mdata, input kind_e k);
    bus.commit_valid     = 1'b1;
    bus.commit_reg_write = rw;
    bus.commit_mem_read  = mr;
    bus.commit_mem_write = mw;
    bus.commit_halt      = h;
    bus.commit_pc        = pc;
    bus.commit_wreg      = wreg;
    bus.commit_wdata     = wdata;
    bus.commit_mem_addr  = addr;
    bus.commit_mem_data  = mdata;
    cur_exp = mk(k, pc, wreg, wdata, addr, mdata);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_valid"}, bus.rd_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk({tag, ".kind"},  bus.rd_kind,  q[0].kind);
      chk({tag, ".inum"},  bus.rd_inum,  q[0].inum);
      chk({tag, ".pc"},    bus.rd_pc,    q[0].pc);
      chk({tag, ".wreg"},  bus.rd_wreg,  q[0].wreg);
      chk({tag, ".wdata"}, bus.rd_wdata, q[0].wdata);
      chk({tag, ".addr"},  bus.rd_addr,  q[0].addr);
      chk({tag, ".mdata"}, bus.rd_mdata, q[0].mdata);
    end
    chk({tag, ".inst"},     inst_count,  m_inst);
    chk({tag, ".cycle"},    cycle_count, m_cycle);
    chk({tag, ".drop"},     drop_count,  m_drop);
    chk({tag, ".overflow"}, overflow,    m_ovf);
    chk({tag, ".halted"},   halted,      m_state == S_DONE);
  endtask

  task automatic model_clear();
    q.delete();
    m_state = S_RUN;
    m_inst  = '0;
    m_cycle = '0;
    m_drop  = '0;
    m_ovf   = 1'b0;
  endtask

  // Advance one clock, updating the model from the inputs as presented before the edge.
  task automatic step(input string tag);
    bit pop_now, full, was_empty, acc;
    trace_entry_t e;
    was_empty = (q.size() == 0);
    pop_now   = bus.rd_ready && !was_empty;
    full      = (q.size() == DEPTH);
    acc       = bus.commit_valid && (m_state == S_RUN);
    if (m_state == S_RUN) m_cycle++;
    if (m_state == S_DRAIN && was_empty) m_state = S_DONE;
    if (pop_now) void'(q.pop_front());
    if (acc) begin
      e      = cur_exp;
      e.inum = m_inst;
      m_inst++;
      if (!full || pop_now) q.push_back(e);
      else begin
        m_drop++;
        m_ovf = 1'b1;
      end
      if (bus.commit_halt) m_state = S_DRAIN;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    bus.commit_valid = 1'b0;
    bus.rd_ready     = 1'b0;
    rst              = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    check_all("reset");
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, output int pops, output logic [2:0] last_kind,
                       output logic [15:0] last_pc, output logic [31:0] last_inum);
    bus.commit_valid = 1'b0;
    bus.rd_ready     = 1'b1;
    pops = 0;
    last_kind = '0;
    last_pc   = '0;
    last_inum = '0;
    for (int i = 0; i < 12 && bus.rd_valid; i++) begin
      last_kind = bus.rd_kind;
      last_pc   = bus.rd_pc;
      last_inum = bus.rd_inum;
      pops++;
      step(tag);
    end
    chk({tag, ".empty_in_bound"}, bus.rd_valid, 1'b0);
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int               pops;
    logic [2:0]       lk;
    logic [15:0]      lpc;
    logic [31:0]      lin;
    logic [CNT_W-1:0] cyc_hold;

    bus.commit_valid = 1'b0; bus.commit_reg_write = 1'b0; bus.commit_mem_read = 1'b0;
    bus.commit_mem_write = 1'b0; bus.commit_halt = 1'b0; bus.commit_pc = '0;
    bus.commit_wreg = '0; bus.commit_wdata = '0; bus.commit_mem_addr = '0;
    bus.commit_mem_data = '0; bus.rd_ready = 1'b0;
    cur_exp = '0;
    model_clear();
    rst = 1'b1;
    @(posedge clk);
    do_reset();
    chk("reset.rd_pc", bus.rd_pc, 16'h0);
    chk("reset.rd_kind", bus.rd_kind, 3'd0);

    // Three classified commits drained as they arrive.
    bus.rd_ready = 1'b1;
    drive(1, 0, 0, 0, 16'h0000, 3'd2, 16'h1234, 16'h0000, 16'h0000, REG);
    step("t1_reg");
    chk("t1_kind_reg", bus.rd_kind, 3'd1);
    chk("t1_inum0", bus.rd_inum, 32'd0);
    chk("t1_wdata", bus.rd_wdata, 16'h1234);
    drive(1, 1, 0, 0, 16'h0002, 3'd3, 16'h00AA, 16'h0040, 16'h7777, LD);
    step("t1_ld");
    chk("t1_kind_ld", bus.rd_kind, 3'd2);
    chk("t1_inum1", bus.rd_inum, 32'd1);
    chk("t1_ld_mdata_zero", bus.rd_mdata, 16'h0);
    drive(0, 0, 1, 0, 16'h0004, 3'd5, 16'h9999, 16'h0042, 16'hBEEF, ST);
    step("t1_st");
    chk("t1_kind_st", bus.rd_kind, 3'd3);
    chk("t1_inum2", bus.rd_inum, 32'd2);
    chk("t1_st_wdata_zero", bus.rd_wdata, 16'h0);
    chk("t1_st_mdata", bus.rd_mdata, 16'hBEEF);
    bus.commit_valid = 1'b0;
    step("t1_idle");

    // Overflow: six commits into four slots with no drain.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 16'(i * 2), 3'(i), 16'(16'h0100 + i), 16'h0, 16'h0, REG);
      step("t2_fill");
    end
    bus.commit_valid = 1'b0;
    chk("t2_drop", drop_count, 32'd2);
    chk("t2_overflow", overflow, 1'b1);
    chk("t2_inst", inst_count, 32'd6);
    chk("t2_head_inum", bus.rd_inum, 32'd0);

    // Full buffer with a simultaneous pop accepts the push.
    bus.rd_ready = 1'b1;
    drive(1, 0, 0, 0, 16'h0100, 3'd7, 16'hAAAA, 16'h0, 16'h0, REG);
    step("t3_push_pop");
    chk("t3_no_drop", drop_count, 32'd2);
    drain("t3_drain", pops, lk, lpc, lin);
    chk("t3_pops", pops, 4);
    chk("t3_last_inum", lin, 32'd6);
    chk("t3_last_pc", lpc, 16'h0100);

    // Halt, then ignored commits while draining is held off.
    do_reset();
    drive(1, 0, 0, 0, 16'h0000, 3'd1, 16'h0011, 16'h0, 16'h0, REG);
    step("t4_c0");
    drive(1, 0, 0, 0, 16'h0002, 3'd2, 16'h0022, 16'h0, 16'h0, REG);
    step("t4_c1");
    drive(1, 0, 1, 1, 16'h0010, 3'd1, 16'h5555, 16'h6666, 16'h7777, HALT);
    step("t4_halt");
    cyc_hold = cycle_count;
    chk("t4_cycle_at_halt", cyc_hold, 32'd3);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 16'h0050, 3'd4, 16'h4444, 16'h0, 16'h0, REG);
      step("t4_ignored");
    end
    chk("t4_cycle_frozen", cycle_count, 32'd3);
    chk("t4_inst_frozen", inst_count, 32'd3);
    chk("t4_not_halted_yet", halted, 1'b0);
    drain("t4_drain", pops, lk, lpc, lin);
    chk("t4_pops", pops, 3);
    chk("t4_last_kind", lk, 3'd5);
    chk("t4_last_pc", lpc, 16'h0010);
    step("t4_done");
    chk("t4_halted", halted, 1'b1);

    // Reset in the middle of a drain.
    do_reset();
    drive(1, 0, 0, 0, 16'h0000, 3'd1, 16'h0001, 16'h0, 16'h0, REG);
    step("t5_c0");
    drive(1, 0, 0, 0, 16'h0002, 3'd1, 16'h0002, 16'h0, 16'h0, REG);
    step("t5_c1");
    drive(0, 0, 0, 1, 16'h0004, 3'd0, 16'h0, 16'h0, 16'h0, HALT);
    step("t5_halt");
    bus.commit_valid = 1'b0;
    bus.rd_ready     = 1'b1;
    step("t5_pop1");
    rst = 1'b1;
    #2;
    model_clear();
    check_all("t5_rst_mid");
    chk("t5_rst_rd_valid", bus.rd_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rd_ready = 1'b0;
    drive(1, 0, 0, 0, 16'h0020, 3'd6, 16'h0606, 16'h0, 16'h0, REG);
    step("t5_after");
    chk("t5_inum0", bus.rd_inum, 32'd0);

    // Store-with-update and load without register write.
    bus.rd_ready = 1'b1;
    drive(1, 0, 1, 0, 16'h0030, 3'd4, 16'h1111, 16'h2222, 16'h3333, STU);
    step("t6_stu");
    chk("t6_kind_stu", bus.rd_kind, 3'd4);
    drive(0, 1, 0, 0, 16'h0032, 3'd2, 16'h5A5A, 16'h0044, 16'h6B6B, NOP);
    step("t6_nop");
    chk("t6_kind_nop", bus.rd_kind, 3'd0);
    chk("t6_nop_addr_zero", bus.rd_addr, 16'h0);
    bus.commit_valid = 1'b0;
    step("t6_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
